// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: accepts a load/store from the core, waits
// LATENCY cycles, then performs the access and pulses ready for one cycle.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  memReadFlag,
  input  logic                  memWriteFlag,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData,
  output logic                  ready,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    rej_q, rej_d;
  logic                    ready_q, ready_d;
  logic                    error_q, error_d;
  logic                    mem_we;
  logic                    req_bad;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  assign req_bad = (memReadFlag & memWriteFlag) | (address[1:0] != 2'b00) |
                   (address[31:ADDR_WIDTH+2] != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    rej_d   = rej_q;
    ready_d = 1'b0;
    error_d = 1'b0;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (memReadFlag | memWriteFlag) begin
          idx_d   = address[ADDR_WIDTH+1:2];
          wdata_d = writeData;
          rd_d    = memReadFlag;
          wr_d    = memWriteFlag;
          rej_d   = req_bad;
          // A rejected request takes a zero-length wait so its ready pulse
          // lands one edge after acceptance, like a LATENCY=0 access.
          cnt_d   = req_bad ? 4'd0 : 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESPOND;
          ready_d = 1'b1;
          error_d = rej_q;
          if (rej_q) begin
            if (rd_q) rdata_d = '0;
          end else if (wr_q) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = mem[idx_q];
          end
        end
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rej_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rej_q   <= rej_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  // Backing store is deliberately not reset; contents survive reset_n.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx_q] <= wdata_q;
  end

  assign readData = rdata_q;
  assign ready    = ready_q;
  assign error    = error_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder at LATENCY=0 (slot 0) and one at LATENCY=2 (slot 1).
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wd    [2];
  logic [31:0] rdata [2];
  logic        rdy   [2];
  logic        err   [2];

  int pass_cnt = 0;
  int tot_cnt  = 0;

  data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(0)) u_lat0 (
    .clock(clk), .reset_n(rst_n), .memReadFlag(rd[0]), .memWriteFlag(wr[0]),
    .address(addr[0]), .writeData(wd[0]), .readData(rdata[0]), .ready(rdy[0]),
    .error(err[0]));

  data_mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(2)) u_lat2 (
    .clock(clk), .reset_n(rst_n), .memReadFlag(rd[1]), .memWriteFlag(wr[1]),
    .address(addr[1]), .writeData(wd[1]), .readData(rdata[1]), .ready(rdy[1]),
    .error(err[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;     // edges from acceptance to ready
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic do_txn(input vec_t v);
    int n;
    rd[v.sel]   = v.rd;
    wr[v.sel]   = v.wr;
    addr[v.sel] = v.addr;
    wd[v.sel]   = v.wd;
    tick();                                  // acceptance edge E0
    addr[v.sel] = ~v.addr;                   // must not disturb the transaction
    wd[v.sel]   = ~v.wd;
    n = 0;
    while (1) begin
      tick();
      n++;
      if (rdy[v.sel] || n >= 40) break;
    end
    rd[v.sel] = 1'b0;
    wr[v.sel] = 1'b0;
    chk({v.name, " latency"}, 32'(n), 32'(v.lat));
    chk({v.name, " error"}, {31'd0, err[v.sel]}, {31'd0, v.err});
    if (v.chk_rd) chk({v.name, " readData"}, rdata[v.sel], v.rdata);
    tick();
    chk({v.name, " ready pulse ends"}, {31'd0, rdy[v.sel]}, 32'd0);
  endtask

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
    end
    rst_n = 1'b0;

    vecs.push_back('{1, 0, 1, 32'h10,  32'hDEADBEEF, 3, 0, 0, 32'h0,        "st 0x10"});
    vecs.push_back('{1, 1, 0, 32'h10,  32'h0,        3, 0, 1, 32'hDEADBEEF, "ld 0x10"});
    vecs.push_back('{1, 0, 1, 32'h20,  32'hCAFE0001, 3, 0, 0, 32'h0,        "st 0x20"});
    vecs.push_back('{1, 1, 0, 32'h13,  32'h0,        1, 1, 1, 32'h0,        "ld misaligned"});
    vecs.push_back('{1, 1, 0, 32'h400, 32'h0,        1, 1, 1, 32'h0,        "ld out of range"});
    vecs.push_back('{1, 1, 1, 32'h20,  32'h12345678, 1, 1, 0, 32'h0,        "both flags"});
    vecs.push_back('{1, 1, 0, 32'h20,  32'h0,        3, 0, 1, 32'hCAFE0001, "ld 0x20 after reject"});
    vecs.push_back('{1, 0, 1, 32'h3FC, 32'hA5A5F00D, 3, 0, 0, 32'h0,        "st top word"});
    vecs.push_back('{1, 1, 0, 32'h3FC, 32'h0,        3, 0, 1, 32'hA5A5F00D, "ld top word"});
    vecs.push_back('{1, 0, 1, 32'h8,   32'h11,       3, 0, 0, 32'h0,        "st 0x8"});
    vecs.push_back('{1, 1, 0, 32'h8,   32'h0,        3, 0, 1, 32'h11,       "ld 0x8"});
    vecs.push_back('{0, 0, 1, 32'h0,   32'h1,        1, 0, 0, 32'h0,        "lat0 st 0x0"});
    vecs.push_back('{0, 0, 1, 32'h4,   32'h2,        1, 0, 0, 32'h0,        "lat0 st 0x4"});
    vecs.push_back('{0, 0, 1, 32'h8,   32'h3,        1, 0, 0, 32'h0,        "lat0 st 0x8"});
    vecs.push_back('{0, 1, 0, 32'h0,   32'h0,        1, 0, 1, 32'h1,        "lat0 ld 0x0"});
    vecs.push_back('{0, 1, 0, 32'h4,   32'h0,        1, 0, 1, 32'h2,        "lat0 ld 0x4"});
    vecs.push_back('{0, 1, 0, 32'h8,   32'h0,        1, 0, 1, 32'h3,        "lat0 ld 0x8"});

    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      chk("reset ready", {31'd0, rdy[i]}, 32'd0);
      chk("reset error", {31'd0, err[i]}, 32'd0);
      chk("reset readData", rdata[i], 32'd0);
    end
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) do_txn(vecs[i]);

    // Reset during WAIT aborts the pending store.
    wr[1] = 1'b1; addr[1] = 32'h8; wd[1] = 32'h55;
    tick();                                  // accepted
    wr[1] = 1'b0;
    tick();                                  // still waiting
    rst_n = 1'b0;
    #1;
    chk("mid-wait reset ready", {31'd0, rdy[1]}, 32'd0);
    chk("mid-wait reset error", {31'd0, err[1]}, 32'd0);
    chk("mid-wait reset readData", rdata[1], 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    do_txn('{1, 1, 0, 32'h8, 32'h0, 3, 0, 1, 32'h11, "ld 0x8 after abort"});

    // Flags held through the ready cycle: the edge leaving RESPOND is not a new acceptance.
    rd[0] = 1'b1; addr[0] = 32'h4;
    tick();                                  // E0
    tick();                                  // E0+1
    chk("held: first ready", {31'd0, rdy[0]}, 32'd1);
    chk("held: first readData", rdata[0], 32'h2);
    tick();                                  // E0+2, back to idle
    chk("held: no ready at E0+2", {31'd0, rdy[0]}, 32'd0);
    tick();                                  // E0+3, second acceptance
    chk("held: no ready at E0+3", {31'd0, rdy[0]}, 32'd0);
    tick();                                  // E0+4
    chk("held: second ready", {31'd0, rdy[0]}, 32'd1);
    rd[0] = 1'b0;
    tick();
    chk("held: second pulse ends", {31'd0, rdy[0]}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
